// File: rtl/rtc_bus_cycle_engine_if.sv
// rtl/rtc_bus_cycle_engine_if.sv - request and pin bundle between RTC control FSM, cycle engine and chip
interface rtc_bus_cycle_engine_if #(
  parameter int DATA_W  = 8,
  parameter int BURST_W = 3
);
  logic               start;
  logic               rw;
  logic [DATA_W-1:0]  addr;
  logic [BURST_W-1:0] len;
  logic [DATA_W-1:0]  wdata;
  logic               wdata_take;
  logic [DATA_W-1:0]  rdata;
  logic               rdata_valid;
  logic               busy;
  logic               done;
  logic               ADo;
  logic               CSo;
  logic               RDo;
  logic               WRo;
  logic [DATA_W-1:0]  AdressDatao;
  logic [DATA_W-1:0]  AdressDatai;
  logic               bus_oe;

  modport slave (
    input  start, rw, addr, len, wdata, AdressDatai,
    output wdata_take, rdata, rdata_valid, busy, done,
           ADo, CSo, RDo, WRo, AdressDatao, bus_oe
  );

  modport master (
    output start, rw, addr, len, wdata, AdressDatai,
    input  wdata_take, rdata, rdata_valid, busy, done,
           ADo, CSo, RDo, WRo, AdressDatao, bus_oe
  );
endinterface

// File: rtl/rtc_bus_cycle_engine.sv
// rtl/rtc_bus_cycle_engine.sv - multiplexed address/data strobe sequencer for the external RTC chip
module rtc_bus_cycle_engine #(
  parameter int DATA_W  = 8,
  parameter int T_PULSE = 4,
  parameter int T_GAP   = 2,
  parameter int BURST_W = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  rtc_bus_cycle_engine_if.slave  bus
);
  localparam int T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(T_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP_A,
    S_DATA,
    S_GAP_D
  } state_t;

  logic [1:0]         rst_sync_q;
  logic               rst_n;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rw_q;
  logic [DATA_W-1:0]  addr_q;
  logic [BURST_W-1:0] rem_q;

  logic               ado_q;
  logic               cso_q;
  logic               rdo_q;
  logic               wro_q;
  logic               oe_q;
  logic [DATA_W-1:0]  dout_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               rvalid_q;
  logic               take_q;
  logic               busy_q;
  logic               done_q;

  // Reset asserts immediately but is released only after two clean clock edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Phase sequencer; every pin value is produced here so the chip sees only flop outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      ado_q    <= 1'b1;
      cso_q    <= 1'b1;
      rdo_q    <= 1'b1;
      wro_q    <= 1'b1;
      oe_q     <= 1'b0;
      dout_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      take_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      take_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            rw_q    <= bus.rw;
            addr_q  <= bus.addr;
            rem_q   <= bus.len;
            state_q <= S_ADDR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            cso_q   <= 1'b0;
            ado_q   <= 1'b0;
            wro_q   <= 1'b0;
            rdo_q   <= 1'b1;
            oe_q    <= 1'b1;
            dout_q  <= bus.addr;
          end
        end
        S_ADDR: begin
          if (cnt_q == PULSE_LAST) begin
            state_q <= S_GAP_A;
            cnt_q   <= '0;
            cso_q   <= 1'b1;
            ado_q   <= 1'b1;
            wro_q   <= 1'b1;
            // Reads release the bus early so the chip can turn it around during the gap.
            oe_q    <= ~rw_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_GAP_A: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            cso_q   <= 1'b0;
            if (rw_q) begin
              rdo_q <= 1'b0;
              oe_q  <= 1'b0;
            end else begin
              // The word is registered on the edge entering DATA so it is on the pins from the first DATA cycle.
              wro_q  <= 1'b0;
              oe_q   <= 1'b1;
              dout_q <= bus.wdata;
              take_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == PULSE_LAST) begin
            state_q <= S_GAP_D;
            cnt_q   <= '0;
            cso_q   <= 1'b1;
            rdo_q   <= 1'b1;
            wro_q   <= 1'b1;
            if (rw_q) begin
              rdata_q  <= bus.AdressDatai;
              rvalid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_GAP_D: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (rem_q == '0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              oe_q    <= 1'b0;
              dout_q  <= '0;
            end else begin
              rem_q   <= rem_q - BURST_W'(1);
              addr_q  <= addr_q + DATA_W'(1);
              state_q <= S_ADDR;
              cso_q   <= 1'b0;
              ado_q   <= 1'b0;
              wro_q   <= 1'b0;
              rdo_q   <= 1'b1;
              oe_q    <= 1'b1;
              dout_q  <= addr_q + DATA_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cso_q   <= 1'b1;
          ado_q   <= 1'b1;
          rdo_q   <= 1'b1;
          wro_q   <= 1'b1;
          oe_q    <= 1'b0;
          dout_q  <= '0;
        end
      endcase
    end
  end

  assign bus.ADo         = ado_q;
  assign bus.CSo         = cso_q;
  assign bus.RDo         = rdo_q;
  assign bus.WRo         = wro_q;
  assign bus.bus_oe      = oe_q;
  assign bus.AdressDatao = dout_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.wdata_take  = take_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_rtc_bus_cycle_engine.sv
// tb/tb_rtc_bus_cycle_engine.sv - randomized self-checking bench for rtc_bus_cycle_engine
module tb_rtc_bus_cycle_engine;
  localparam int DW = 8;
  localparam int BW = 3;
  localparam int TP = 4;
  localparam int TG = 2;
  localparam int P  = 2 * (TP + TG);

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  int   done_seen;
  int   rv_seen;

  logic [7:0] mem [256];
  logic [7:0] lat;

  // model state
  logic       m_act;
  int         m_t0;
  logic       m_rw;
  logic [7:0] m_addr;
  int         m_len;
  logic [7:0] m_w0;
  logic [7:0] m_rdata;

  logic       e_ad, e_cs, e_rd, e_wr, e_oe, e_take, e_rv, e_busy, e_done, e_dochk;
  logic [7:0] e_do;

  rtc_bus_cycle_engine_if #(.DATA_W(DW), .BURST_W(BW)) bus ();

  rtc_bus_cycle_engine #(
    .DATA_W (DW),
    .T_PULSE(TP),
    .T_GAP  (TG),
    .BURST_W(BW)
  ) dut (
    .clock(clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic at_cycle(input int c);
    goto_cycle(c);
    @(negedge clk);
  endtask

  task automatic issue(input logic r, input logic [7:0] a, input logic [2:0] l,
                       input logic [7:0] w, output int c0);
    bus.start = 1'b1;
    bus.rw    = r;
    bus.addr  = a;
    bus.len   = l;
    bus.wdata = w;
    c0 = cyc;
    next_cycle();
    bus.start = 1'b0;
    bus.rw    = 1'($urandom);
    bus.addr  = 8'($urandom);
    bus.len   = 3'($urandom);
  endtask

  // Chip model: latches the address on ADo low and returns its register contents; controller side advances wdata on each take.
  initial begin
    lat = 8'h00;
    bus.AdressDatai = 8'h00;
    forever begin
      next_cycle();
      if (bus.ADo === 1'b0) lat = bus.AdressDatao;
      bus.AdressDatai = mem[lat];
      if (bus.wdata_take === 1'b1) bus.wdata = bus.wdata + 8'h35;
    end
  end

  // Reference timeline: position within the request decides every pin; checked each cycle, then new requests are accepted.
  always @(negedge clk) begin
    int n, k, o, tot;
    logic [7:0] ak;
    e_ad = 1; e_cs = 1; e_rd = 1; e_wr = 1; e_oe = 0; e_do = 8'h00; e_dochk = 1;
    e_take = 0; e_rv = 0; e_busy = 0; e_done = 0;
    if (!reset) begin
      m_act   = 0;
      m_rdata = 8'h00;
    end else if (m_act) begin
      n   = cyc - m_t0;
      tot = (m_len + 1) * P;
      if (n >= 1 && n <= tot) begin
        k  = (n - 1) / P;
        o  = (n - 1) % P;
        ak = m_addr + k[7:0];
        e_busy = 1;
        if (o < TP) begin
          e_cs = 0; e_ad = 0; e_wr = 0; e_oe = 1; e_do = ak;
        end else if (o < TP + TG) begin
          e_oe = !m_rw; e_do = ak;
        end else if (o < 2 * TP + TG) begin
          e_cs = 0;
          if (m_rw) begin
            e_rd = 0; e_dochk = 0;
          end else begin
            e_wr = 0; e_oe = 1; e_do = m_w0 + 8'(k * 53); e_take = (o == TP + TG);
          end
        end else begin
          if (m_rw) begin
            e_dochk = 0;
            if (o == 2 * TP + TG) begin
              e_rv = 1;
              m_rdata = mem[ak];
            end
          end else begin
            e_oe = 1; e_do = m_w0 + 8'(k * 53);
          end
        end
      end else if (n == tot + 1) begin
        e_done = 1;
      end else begin
        m_act = 0;
      end
    end
    check("ADo", bus.ADo, e_ad);
    check("CSo", bus.CSo, e_cs);
    check("RDo", bus.RDo, e_rd);
    check("WRo", bus.WRo, e_wr);
    check("bus_oe", bus.bus_oe, e_oe);
    if (e_dochk) check("AdressDatao", bus.AdressDatao, e_do);
    check("wdata_take", bus.wdata_take, e_take);
    check("rdata_valid", bus.rdata_valid, e_rv);
    check("rdata", bus.rdata, m_rdata);
    check("busy", bus.busy, e_busy);
    check("done", bus.done, e_done);
    if (bus.done === 1'b1) done_seen++;
    if (bus.rdata_valid === 1'b1) rv_seen++;
    if (reset && bus.start && !e_busy) begin
      m_act  = 1;
      m_t0   = cyc;
      m_rw   = bus.rw;
      m_addr = bus.addr;
      m_len  = int'(bus.len);
      m_w0   = bus.wdata;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0, r0, tot, x;
    logic [7:0] a;
    logic [2:0] l;
    logic       r;
    cyc = 0; total = 0; bad = 0; done_seen = 0; rv_seen = 0;
    m_act = 0; m_t0 = 0; m_rw = 0; m_addr = 0; m_len = 0; m_w0 = 0; m_rdata = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h22] = 8'h59;
    reset = 1'b0;
    bus.start = 0; bus.rw = 0; bus.addr = 0; bus.len = 0; bus.wdata = 0;

    // reset state
    at_cycle(3);
    check("rst_ADo", bus.ADo, 1);
    check("rst_CSo", bus.CSo, 1);
    check("rst_RDo", bus.RDo, 1);
    check("rst_WRo", bus.WRo, 1);
    check("rst_oe", bus.bus_oe, 0);
    check("rst_dout", bus.AdressDatao, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_busy", bus.busy, 0);
    next_cycle();
    reset = 1'b1;
    repeat (5) next_cycle();

    // single write
    issue(1'b0, 8'h21, 3'd0, 8'h45, c0);
    at_cycle(c0 + 1);  check("w_WRo_c1", bus.WRo, 0); check("w_addr_c1", bus.AdressDatao, 8'h21);
    at_cycle(c0 + 4);  check("w_WRo_c4", bus.WRo, 0);
    at_cycle(c0 + 6);  check("w_addr_c6", bus.AdressDatao, 8'h21);
    at_cycle(c0 + 7);  check("w_data_c7", bus.AdressDatao, 8'h45); check("w_take_c7", bus.wdata_take, 1);
    at_cycle(c0 + 10); check("w_WRo_c10", bus.WRo, 0);
    at_cycle(c0 + 12); check("w_data_c12", bus.AdressDatao, 8'h45);
    at_cycle(c0 + 13); check("w_done_c13", bus.done, 1); check("w_busy_c13", bus.busy, 0);
    next_cycle();

    // single read
    issue(1'b1, 8'h22, 3'd0, 8'h00, c0);
    at_cycle(c0 + 5);  check("r_oe_c5", bus.bus_oe, 0);
    at_cycle(c0 + 7);  check("r_RDo_c7", bus.RDo, 0);
    at_cycle(c0 + 11); check("r_rdata_c11", bus.rdata, 8'h59); check("r_valid_c11", bus.rdata_valid, 1);
    at_cycle(c0 + 13); check("r_done_c13", bus.done, 1);
    next_cycle();

    // burst read with address wrap
    r0 = rv_seen;
    issue(1'b1, 8'hFE, 3'd2, 8'h00, c0);
    at_cycle(c0 + 1);  check("b_addr0", bus.AdressDatao, 8'hFE);
    at_cycle(c0 + 13); check("b_addr1", bus.AdressDatao, 8'hFF);
    at_cycle(c0 + 25); check("b_addr2", bus.AdressDatao, 8'h00);
    at_cycle(c0 + 37); check("b_done_c37", bus.done, 1);
    check("b_rvalid_cnt", rv_seen - r0, 3);
    next_cycle();

    // start while busy is ignored
    d0 = done_seen;
    issue(1'b0, 8'h10, 3'd0, 8'h3C, c0);
    goto_cycle(c0 + 5);
    bus.start = 1'b1; bus.rw = 1'b1; bus.addr = 8'h99; bus.len = 3'd5;
    next_cycle();
    bus.start = 1'b0;
    at_cycle(c0 + 20);
    check("ign_done_cnt", done_seen - d0, 1);
    next_cycle();

    // reset in the middle of a write
    d0 = done_seen; r0 = rv_seen;
    issue(1'b0, 8'h30, 3'd0, 8'h77, c0);
    goto_cycle(c0 + 8);
    reset = 1'b0;
    @(negedge clk);
    check("mr_WRo", bus.WRo, 1);
    check("mr_CSo", bus.CSo, 1);
    check("mr_oe", bus.bus_oe, 0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    repeat (20) next_cycle();
    check("mr_no_done", done_seen - d0, 0);
    check("mr_no_rvalid", rv_seen - r0, 0);
    issue(1'b0, 8'h31, 3'd0, 8'h12, c0);
    at_cycle(c0 + 13);
    check("mr_after_done", bus.done, 1);
    next_cycle();

    // start held through the done cycle
    bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 8'h40; bus.len = 3'd0; bus.wdata = 8'h11;
    c0 = cyc;
    at_cycle(c0 + 13);
    check("h_done_c13", bus.done, 1);
    goto_cycle(c0 + 14);
    bus.start = 1'b0;
    @(negedge clk);
    check("h_ADo_c14", bus.ADo, 0);
    check("h_addr_c14", bus.AdressDatao, 8'h40);
    goto_cycle(c0 + 28);

    // randomized requests
    for (int it = 0; it < 30; it++) begin
      r = 1'($urandom);
      a = 8'($urandom);
      l = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
      issue(r, a, l, 8'($urandom), c0);
      tot = (int'(l) + 1) * P;
      if ($urandom_range(0, 1) == 1) begin
        x = $urandom_range(1, tot);
        goto_cycle(c0 + x);
        bus.start = 1'b1; bus.rw = 1'($urandom); bus.addr = 8'($urandom); bus.len = 3'($urandom);
        next_cycle();
        bus.start = 1'b0;
      end
      goto_cycle(c0 + tot + 1);
      repeat ($urandom_range(0, 3)) next_cycle();
    end
    repeat (5) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
